// File: rtl/cve2_pkg.sv
// -----------------------------------------------------------------------------
// cve2_pkg
// Shared types for the CVE2 OBI bus arbiter slice.
//   obi_owner_e : which core port issued a bus transaction
//   arb_state_e : arbiter request-lock state
//   other_owner : helper returning the opposite port (round-robin pick)
// -----------------------------------------------------------------------------
package cve2_pkg;

  typedef enum logic {
    OBI_OWNER_INSTR = 1'b0,
    OBI_OWNER_DATA  = 1'b1
  } obi_owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD_I = 2'd1,
    ARB_HOLD_D = 2'd2
  } arb_state_e;

  // Byte enables used for instruction fetches (always full word).
  localparam logic [3:0] OBI_BE_ALL = 4'hF;

  function automatic obi_owner_e other_owner(input obi_owner_e owner);
    return (owner == OBI_OWNER_DATA) ? OBI_OWNER_INSTR : OBI_OWNER_DATA;
  endfunction

endpackage

// File: rtl/cve2_obi_owner_fifo.sv
// -----------------------------------------------------------------------------
// cve2_obi_owner_fifo
// In-order record of which port owns each granted-but-unanswered transaction.
// One entry per outstanding transaction; the head is the owner of the next
// response.
//   clk_i, rst_ni  : clock, async active-low reset (FIFO empties on reset)
//   push_i         : a transaction was granted this cycle
//   push_owner_i   : port that received the grant
//   pop_i          : a response arrived this cycle (caller gates with !empty_o)
//   head_o         : owner of the oldest outstanding transaction
//   full_o/empty_o : occupancy flags
//   count_o        : number of outstanding transactions
// -----------------------------------------------------------------------------
module cve2_obi_owner_fifo
  import cve2_pkg::*;
#(
  parameter  int unsigned Depth = 2,
  localparam int unsigned CntW  = $clog2(Depth + 1),
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  obi_owner_e      push_owner_i,
  input  logic            pop_i,
  output obi_owner_e      head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  obi_owner_e      mem_q [Depth];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // NOTE: every signal driven here gets a value before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) wptr_d = ptr_inc(wptr_q);
    if (pop_i)  rptr_d = ptr_inc(rptr_q);
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;  // idle, or push and pop cancel out
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array has no reset; an entry is only read after it has
  // been written, because the pointers and count are reset instead.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= push_owner_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/cve2_obi_arbiter.sv
// -----------------------------------------------------------------------------
// cve2_obi_arbiter
// Two-to-one OBI arbiter merging the core's instruction-fetch and data ports
// onto one memory bus. Responses are routed back in grant order using an
// owner FIFO. Zero added latency on both request and response paths.
//
// Parameters
//   MaxOutstanding : granted-but-unanswered transactions allowed (1..4)
//   DataPriority   : winner of the first conflict after reset (1 = data)
//
// Ports
//   clk_i, rst_ni             : clock, async active-low reset
//   instr_*                   : core fetch port (req/gnt/rvalid/addr/rdata/err)
//   data_*                    : core load/store port (adds we/be/wdata)
//   bus_*                     : shared memory bus
//   busy_o                    : transactions outstanding or a request pending
//   unexp_rvalid_o            : sticky, response seen with nothing outstanding
// -----------------------------------------------------------------------------
module cve2_obi_arbiter
  import cve2_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter logic        DataPriority   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i,

  output logic        busy_o,
  output logic        unexp_rvalid_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  arb_state_e      state_q, state_d;
  obi_owner_e      last_winner_q, last_winner_d;
  obi_owner_e      sel_owner;
  logic            sel_valid;
  logic            unexp_q, unexp_d;

  logic            push, pop;
  obi_owner_e      head_owner;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;

  // ---------------------------------------------------------------------------
  // Arbitration. Fullness uses the registered count only, so a response in
  // the same cycle cannot unblock a request (no rvalid->req path).
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    last_winner_d = last_winner_q;
    sel_valid     = 1'b0;
    sel_owner     = OBI_OWNER_INSTR;

    unique case (state_q)
      ARB_IDLE: begin
        if (!fifo_full) begin
          if (instr_req_i && data_req_i) begin
            sel_valid     = 1'b1;
            sel_owner     = other_owner(last_winner_q);
            last_winner_d = sel_owner;
          end else if (data_req_i) begin
            sel_valid = 1'b1;
            sel_owner = OBI_OWNER_DATA;
          end else if (instr_req_i) begin
            sel_valid = 1'b1;
            sel_owner = OBI_OWNER_INSTR;
          end
          // Lock the selection until granted so the payload stays stable.
          if (sel_valid && !bus_gnt_i) begin
            state_d = (sel_owner == OBI_OWNER_DATA) ? ARB_HOLD_D : ARB_HOLD_I;
          end
        end
      end
      ARB_HOLD_I: begin
        sel_owner = OBI_OWNER_INSTR;
        sel_valid = instr_req_i;
        if (bus_gnt_i || !instr_req_i) state_d = ARB_IDLE;
      end
      ARB_HOLD_D: begin
        sel_owner = OBI_OWNER_DATA;
        sel_valid = data_req_i;
        if (bus_gnt_i || !data_req_i) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Request payload mux; idle bus drives zeros.
  always_comb begin
    bus_req_o   = sel_valid;
    bus_we_o    = 1'b0;
    bus_be_o    = 4'h0;
    bus_addr_o  = 32'h0;
    bus_wdata_o = 32'h0;
    if (sel_valid) begin
      if (sel_owner == OBI_OWNER_DATA) begin
        bus_we_o    = data_we_i;
        bus_be_o    = data_be_i;
        bus_addr_o  = data_addr_i;
        bus_wdata_o = data_wdata_i;
      end else begin
        bus_be_o    = OBI_BE_ALL;
        bus_addr_o  = instr_addr_i;
      end
    end
  end

  assign push        = bus_req_o & bus_gnt_i;
  assign instr_gnt_o = push & (sel_owner == OBI_OWNER_INSTR);
  assign data_gnt_o  = push & (sel_owner == OBI_OWNER_DATA);

  // ---------------------------------------------------------------------------
  // Response routing: the FIFO head names the owner of this response.
  // ---------------------------------------------------------------------------
  assign pop            = bus_rvalid_i & ~fifo_empty;
  assign instr_rvalid_o = pop & (head_owner == OBI_OWNER_INSTR);
  assign data_rvalid_o  = pop & (head_owner == OBI_OWNER_DATA);
  assign instr_err_o    = instr_rvalid_o & bus_err_i;
  assign data_err_o     = data_rvalid_o & bus_err_i;
  assign instr_rdata_o  = bus_rdata_i;
  assign data_rdata_o   = bus_rdata_i;

  assign unexp_d        = unexp_q | (bus_rvalid_i & fifo_empty);
  assign unexp_rvalid_o = unexp_q;
  assign busy_o         = (fifo_count != '0) | instr_req_i | data_req_i;

  cve2_obi_owner_fifo #(
    .Depth (MaxOutstanding)
  ) u_owner_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (push),
    .push_owner_i (sel_owner),
    .pop_i        (pop),
    .head_o       (head_owner),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ARB_IDLE;
      last_winner_q <= obi_owner_e'(~DataPriority);
      unexp_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      unexp_q       <= unexp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------------
  // An ungranted request must present the same payload next cycle.
  a_payload_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus_req_o && !bus_gnt_i) |=> (!bus_req_o || ($stable(bus_addr_o) &&
      $stable(bus_we_o) && $stable(bus_be_o) && $stable(bus_wdata_o))));

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> !fifo_full);

  // A response in the same cycle as the grant of the only transaction.
  a_no_zero_latency: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && bus_rvalid_i && fifo_empty));

endmodule

// File: tb/tb_cve2_obi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cve2_obi_arbiter
// Directed scenarios followed by randomized traffic, compared every cycle
// against a transaction-level model (owner queue, conflict winner, held port).
// -----------------------------------------------------------------------------
module tb_cve2_obi_arbiter;

  localparam int MAXO = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        instr_req_i = 1'b0, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i = '0, instr_rdata_o;
  logic        data_req_i = 1'b0, data_gnt_o, data_rvalid_o, data_err_o;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_addr_i = '0, data_wdata_i = '0, data_rdata_o;
  logic        bus_req_o, bus_gnt_i = 1'b0, bus_rvalid_i = 1'b0, bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i = '0;
  logic        bus_err_i = 1'b0, busy_o, unexp_rvalid_o;

  always #5 clk_i = ~clk_i;

  cve2_obi_arbiter #(
    .MaxOutstanding (MAXO),
    .DataPriority   (1'b1)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .instr_req_i    (instr_req_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_addr_i   (instr_addr_i),
    .instr_rdata_o  (instr_rdata_o),
    .instr_err_o    (instr_err_o),
    .data_req_i     (data_req_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_rdata_o   (data_rdata_o),
    .data_err_o     (data_err_o),
    .bus_req_o      (bus_req_o),
    .bus_gnt_i      (bus_gnt_i),
    .bus_rvalid_i   (bus_rvalid_i),
    .bus_we_o       (bus_we_o),
    .bus_be_o       (bus_be_o),
    .bus_addr_o     (bus_addr_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_rdata_i    (bus_rdata_i),
    .bus_err_i      (bus_err_i),
    .busy_o         (busy_o),
    .unexp_rvalid_o (unexp_rvalid_o)
  );

  int tests  = 0;
  int failed = 0;

  // Model state: owners of outstanding transactions (1 = data), port whose
  // request is locked waiting for a grant (-1 none), last conflict winner.
  bit owner_q[$];
  int held;
  bit last_conf_data;
  bit unexp_m;

  // Model decisions for the current cycle.
  bit e_req, e_sel, e_conflict, e_pop, e_head;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner_q.delete();
    held           = -1;
    last_conf_data = 1'b0;  // first conflict goes to data
    unexp_m        = 1'b0;
  endtask

  task automatic model_eval();
    bit full;
    full       = (owner_q.size() == MAXO);
    e_req      = 1'b0;
    e_sel      = 1'b0;
    e_conflict = 1'b0;
    if (held == 0) begin
      e_sel = 1'b0; e_req = instr_req_i;
    end else if (held == 1) begin
      e_sel = 1'b1; e_req = data_req_i;
    end else if (!full) begin
      if (instr_req_i && data_req_i) begin
        e_conflict = 1'b1; e_sel = !last_conf_data; e_req = 1'b1;
      end else if (data_req_i) begin
        e_sel = 1'b1; e_req = 1'b1;
      end else if (instr_req_i) begin
        e_sel = 1'b0; e_req = 1'b1;
      end
    end
    e_pop  = bus_rvalid_i && (owner_q.size() > 0);
    e_head = (owner_q.size() > 0) ? owner_q[0] : 1'b0;
  endtask

  task automatic check_all();
    logic [31:0] ea, ew;
    logic [3:0]  ebe;
    logic        ewe;
    bit          g;
    ea = '0; ew = '0; ebe = '0; ewe = 1'b0;
    if (e_req && e_sel) begin
      ea = data_addr_i; ew = data_wdata_i; ebe = data_be_i; ewe = data_we_i;
    end else if (e_req) begin
      ea = instr_addr_i; ebe = 4'hF;
    end
    g = e_req && bus_gnt_i;
    check("bus_req",      bus_req_o,      e_req);
    check("bus_addr",     bus_addr_o,     ea);
    check("bus_we",       bus_we_o,       ewe);
    check("bus_be",       bus_be_o,       ebe);
    check("bus_wdata",    bus_wdata_o,    ew);
    check("instr_gnt",    instr_gnt_o,    g && !e_sel);
    check("data_gnt",     data_gnt_o,     g && e_sel);
    check("instr_rvalid", instr_rvalid_o, e_pop && !e_head);
    check("data_rvalid",  data_rvalid_o,  e_pop && e_head);
    check("instr_err",    instr_err_o,    e_pop && !e_head && bus_err_i);
    check("data_err",     data_err_o,     e_pop && e_head && bus_err_i);
    check("instr_rdata",  instr_rdata_o,  bus_rdata_i);
    check("data_rdata",   data_rdata_o,   bus_rdata_i);
    check("busy",         busy_o,         (owner_q.size() != 0) || instr_req_i || data_req_i);
    check("unexp",        unexp_rvalid_o, unexp_m);
  endtask

  task automatic model_update();
    int sz;
    sz = owner_q.size();
    if (e_pop) void'(owner_q.pop_front());
    if (e_req && bus_gnt_i) owner_q.push_back(e_sel);
    if (bus_rvalid_i && sz == 0) unexp_m = 1'b1;
    held = (e_req && !bus_gnt_i) ? int'(e_sel) : -1;
    if (e_conflict) last_conf_data = e_sel;
  endtask

  // Inputs are set after an edge; settle evaluates and checks mid-cycle.
  task automatic settle();
    #1;
    model_eval();
    check_all();
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_update();
    #2;
  endtask

  task automatic idle_inputs();
    instr_req_i = 1'b0; data_req_i = 1'b0; bus_gnt_i = 1'b0;
    bus_rvalid_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = '0;
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && owner_q.size() > 0; k++) begin
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = $urandom;
      settle();
      tick();
    end
    bus_rvalid_i = 1'b0;
    check("drain_empty", owner_q.size(), 0);
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    model_reset();
    @(posedge clk_i);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ig, dg;
    idle_inputs();
    apply_reset();

    // Reset state: everything quiet.
    settle();
    check("rst_bus_req", bus_req_o, 0);
    check("rst_busy", busy_o, 0);
    tick();

    // Single fetch with a one-cycle response.
    instr_req_i = 1'b1; instr_addr_i = 32'h80; bus_gnt_i = 1'b1;
    settle();
    check("t1_addr", bus_addr_o, 32'h80);
    check("t1_be", bus_be_o, 4'hF);
    check("t1_igrant", instr_gnt_o, 1);
    tick();
    instr_req_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h13;
    settle();
    check("t1_irvalid", instr_rvalid_o, 1);
    check("t1_rdata", instr_rdata_o, 32'h13);
    check("t1_drvalid", data_rvalid_o, 0);
    tick();
    idle_inputs();

    // Both ports requesting with an always-granting bus: D,I,D,I,...
    instr_req_i = 1'b1; instr_addr_i = 32'h100;
    data_req_i = 1'b1; data_addr_i = 32'h400; data_we_i = 1'b0; data_be_i = 4'hF;
    bus_gnt_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus_rvalid_i = (owner_q.size() > 0);
      bus_rdata_i  = 32'hA000 + k;
      settle();
      check("rr_dgnt", data_gnt_o, (k % 2) == 0);
      check("rr_ignt", instr_gnt_o, (k % 2) == 1);
      tick();
    end
    instr_req_i = 1'b0; data_req_i = 1'b0; bus_gnt_i = 1'b0;
    drain();

    // Data request held without grant; instr joins later and must wait.
    data_req_i = 1'b1; data_addr_i = 32'h1000; data_we_i = 1'b1; data_be_i = 4'h3;
    data_wdata_i = 32'hDEADBEEF; instr_addr_i = 32'h200;
    for (int k = 0; k < 3; k++) begin
      instr_req_i = (k >= 1);
      settle();
      check("hold_addr", bus_addr_o, 32'h1000);
      check("hold_be", bus_be_o, 4'h3);
      tick();
    end
    bus_gnt_i = 1'b1;
    settle();
    check("hold_dgnt", data_gnt_o, 1);
    check("hold_igrant_blocked", instr_gnt_o, 0);
    tick();
    data_req_i = 1'b0;
    settle();
    check("hold_igrant", instr_gnt_o, 1);
    check("hold_iaddr", bus_addr_o, 32'h200);
    tick();
    instr_req_i = 1'b0; bus_gnt_i = 1'b0;
    drain();

    // Fill to MaxOutstanding; a response in the full cycle still blocks.
    instr_req_i = 1'b1; instr_addr_i = 32'h300; bus_gnt_i = 1'b1;
    settle(); tick();
    settle(); tick();
    settle();
    check("full_blocks", bus_req_o, 0);
    tick();
    bus_rvalid_i = 1'b1;
    settle();
    check("full_pop_blocks", bus_req_o, 0);
    check("full_pop_rvalid", instr_rvalid_o, 1);
    tick();
    bus_rvalid_i = 1'b0;
    settle();
    check("full_reissue", bus_req_o, 1);
    check("full_reissue_gnt", instr_gnt_o, 1);
    tick();
    instr_req_i = 1'b0; bus_gnt_i = 1'b0;
    drain();

    // Two fetches outstanding, then a data access answered with an error.
    instr_req_i = 1'b1; instr_addr_i = 32'h500; bus_gnt_i = 1'b1;
    settle(); tick();
    settle(); tick();
    instr_req_i = 1'b0;
    data_req_i = 1'b1; data_addr_i = 32'h2000; data_we_i = 1'b0; data_be_i = 4'hF;
    bus_rvalid_i = 1'b1; bus_err_i = 1'b0;
    settle();
    check("err_dblocked", data_gnt_o, 0);
    tick();
    settle();
    check("err_dgnt", data_gnt_o, 1);
    check("err_irvalid", instr_rvalid_o, 1);
    tick();
    data_req_i = 1'b0; bus_gnt_i = 1'b0; bus_err_i = 1'b1;
    settle();
    check("err_drvalid", data_rvalid_o, 1);
    check("err_derr", data_err_o, 1);
    check("err_ierr", instr_err_o, 0);
    tick();
    idle_inputs();

    // Response with nothing outstanding.
    bus_rvalid_i = 1'b1;
    settle();
    check("unexp_no_irvalid", instr_rvalid_o, 0);
    check("unexp_no_drvalid", data_rvalid_o, 0);
    tick();
    bus_rvalid_i = 1'b0;
    settle();
    check("unexp_set", unexp_rvalid_o, 1);
    check("unexp_busy", busy_o, 0);
    tick();
    settle();
    check("unexp_sticky", unexp_rvalid_o, 1);
    tick();

    // Reset clears the flag; a reset mid-transaction drops tracking.
    apply_reset();
    settle();
    check("rst_unexp_clr", unexp_rvalid_o, 0);
    tick();
    instr_req_i = 1'b1; instr_addr_i = 32'h600; bus_gnt_i = 1'b1;
    settle(); tick();
    instr_req_i = 1'b0; bus_gnt_i = 1'b0;
    settle();
    check("mid_busy", busy_o, 1);
    apply_reset();
    settle();
    check("mid_rst_busy", busy_o, 0);
    tick();
    bus_rvalid_i = 1'b1;
    settle();
    check("late_no_irvalid", instr_rvalid_o, 0);
    tick();
    bus_rvalid_i = 1'b0;
    settle();
    check("late_unexp", unexp_rvalid_o, 1);
    tick();

    // Randomized traffic; masters hold request and payload until granted.
    for (int i = 0; i < 400; i++) begin
      if (!instr_req_i && ($urandom_range(1, 0) == 1)) begin
        instr_req_i  = 1'b1;
        instr_addr_i = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_req_i && ($urandom_range(1, 0) == 1)) begin
        data_req_i   = 1'b1;
        data_we_i    = ($urandom_range(1, 0) == 1);
        data_be_i    = 4'($urandom_range(15, 1));
        data_addr_i  = $urandom & 32'hFFFF_FFFC;
        data_wdata_i = $urandom;
      end
      bus_gnt_i    = ($urandom_range(1, 0) == 1);
      bus_rvalid_i = (owner_q.size() > 0) && ($urandom_range(1, 0) == 1);
      bus_err_i    = bus_rvalid_i && ($urandom_range(3, 0) == 0);
      bus_rdata_i  = $urandom;
      settle();
      ig = e_req && bus_gnt_i && !e_sel;
      dg = e_req && bus_gnt_i && e_sel;
      tick();
      if (ig) instr_req_i = 1'b0;
      if (dg) data_req_i = 1'b0;
    end
    instr_req_i = 1'b0; data_req_i = 1'b0; bus_gnt_i = 1'b0; bus_err_i = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
